float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
- Sequential converter from IEEE-754 single-precision float (E=8, M=23) to a signed two's-complement integer.
- Rounds toward zero, i.e. truncates.
- It is the reverse of the float datapath's pack stage: it unpacks sign, exponent and mantissa, aligns with a one-bit-per-cycle iterative shifter, and applies sign.
- Valid/ready on both sides. Used where float results feed integer counters or addresses.

Parameters:
- E, 8, exponent field width
- M, 23, mantissa field width (hidden bit excluded)
- Width, 32, float word width (= 1+E+M)
- IW, 32, integer output width; must satisfy IW-1 > M
- BIAS, 127, exponent bias (= 2^(E-1)-1)

Ports:
- clk, in, 1, clock; all state updates on rising edge
- rst, in, 1, synchronous active-high reset
- in_valid, in, 1, in_data valid
- in_ready, out, 1, converter can accept; high only in IDLE
- in_data, in, Width, float operand {s, e[E-1:0], m[M-1:0]}
- out_valid, out, 1, out_data/out_flags valid
- out_ready, in, 1, consumer accepts result
- out_data, out, IW, signed integer result
- out_flags, out, 3, {invalid, overflow, inexact}

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0. rst has priority over all other events; an in-flight conversion is dropped silently with no output.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Acceptance: in_valid & in_ready at an edge. The operand is latched and classified that edge, with ue = e - BIAS (signed, E+1 bits):
  - NaN (e=all-ones, m!=0): result 2^(IW-1)-1; flags=100; go to DONE.
  - Inf (e=all-ones, m=0): result saturates to 2^(IW-1)-1 (s=0) or -2^(IW-1) (s=1); flags=010; go to DONE.
  - |x|<1 (e<BIAS, including zero and denormals): result 0; inexact=(e!=0 | m!=0); go to DONE. Result is 0, never -0.
  - ue > IW-1, or ue = IW-1 and not exactly -2^(IW-1) (s=1, m=0): saturate per sign; flags=010; go to DONE.
  - Otherwise: acc = {1, m} zero-extended to IW bits, sticky=0, dir = left if ue > M else right, cnt = |ue - M|. Go to SHIFT if cnt != 0, else to DONE.
- SHIFT: each cycle shifts acc by 1 in dir and decrements cnt. On a right shift, sticky |= the bit shifted out. When cnt reaches 1, the final shift happens that same cycle and the state moves to DONE.
- Entering DONE from the shift path: out_data = s ? -acc : acc (IW-bit two's complement, wraps correctly for -2^(IW-1)); out_flags = {0, 0, sticky}.
- Latency: out_valid rises at edge T+1+n after acceptance edge T, where n = shift count (0 for special cases). Worst case is n=M (ue=0).
- DONE: out_data/out_flags held stable while out_valid=1 and out_ready=0. out_valid & out_ready at an edge moves to IDLE. No same-cycle re-accept; in_ready rises the following cycle.
- in_data is ignored outside IDLE. in_valid may drop at any time without effect once accepted.
- out_ready is ignored outside DONE.
- Throughput: one conversion per n+3 cycles minimum.

Test Plan:
- 0x3F800000 (1.0) accepted at T -> out_valid at T+24, out_data=0x00000001, flags=000.
- 0xC0200000 (-2.5) -> n=22, out_data=0xFFFFFFFE, flags=001.
- 0x4E800000 (2^30) -> left shift n=7, out_data=0x40000000, flags=000. 0xCF000000 (-2^31) -> out_data=0x80000000, flags=000. 0x4F000000 (+2^31) -> 0x7FFFFFFF, flags=010 at T+1.
- 0x7FC00000 (NaN) -> T+1, out_data=0x7FFFFFFF, flags=100. 0xFF800000 (-Inf) -> 0x80000000, flags=010. 0x3F000000 (0.5) -> 0, flags=001. 0x80000000 (-0) -> 0, flags=000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/flags stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-SHIFT (rst at cycle 5 of converting 1.0) -> next cycle IDLE, out_valid=0, out_data=0. A new conversion of 0x40400000 (3.0) then yields 0x00000003.

Source files
------------

// File: rtl/float_to_int_if.sv
// Handshake bundle for the float-to-int converter: a float operand stream in,
// an integer result stream (with exception flags) out.
interface float_to_int_if #(
    parameter int unsigned Width = 32,
    parameter int unsigned IW    = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    out_data;
    logic [2:0]       out_flags;  // {invalid, overflow, inexact}

    // Producer of operands / consumer of results
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_flags
    );

    // The converter itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_flags
    );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to signed integer converter, truncating toward
// zero. Special cases resolve on the accept edge; normal operands are aligned
// by a one-bit-per-cycle shifter before the sign is applied.
module float_to_int #(
    parameter int unsigned E     = 8,
    parameter int unsigned M     = 23,
    parameter int unsigned Width = 1 + E + M,
    parameter int unsigned IW    = 32,
    parameter int unsigned BIAS  = (1 << (E - 1)) - 1
) (
    input logic          clk_i,
    input logic          rst_i,
    float_to_int_if.slave bus
);
    localparam int unsigned CW   = $clog2(IW) + 1;
    localparam int          IwM1 = int'(IW) - 1;
    localparam int          MI   = int'(M);

    localparam logic [IW-1:0] MaxPos = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0] MinNeg = {1'b1, {(IW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            sign_q, sign_d;
    logic            sticky_q, sticky_d;
    logic [IW-1:0]   data_q, data_d;
    logic [2:0]      flags_q, flags_d;

    // Operand unpacking
    logic            sgn;
    logic [E-1:0]    exp_f;
    logic [M-1:0]    man;
    logic            exp_ones;
    logic            man_nz;
    logic [IW-1:0]   acc_init;
    int              ue;

    assign sgn      = bus.in_data[Width-1];
    assign exp_f    = bus.in_data[Width-2 -: E];
    assign man      = bus.in_data[M-1:0];
    assign exp_ones = &exp_f;
    assign man_nz   = |man;
    assign acc_init = {{(IW-M-1){1'b0}}, 1'b1, man};
    assign ue       = int'({1'b0, exp_f}) - int'(BIAS);

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = data_q;
    assign bus.out_flags = flags_q;

    // Next-state: classify on accept, iterate the aligner, release on handshake
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        data_d   = data_q;
        flags_d  = flags_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sign_d   = sgn;
                    sticky_d = 1'b0;
                    acc_d    = acc_init;
                    left_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = StDone;
                    if (exp_ones && man_nz) begin
                        data_d  = MaxPos;
                        flags_d = 3'b100;
                    end else if (exp_ones) begin
                        data_d  = sgn ? MinNeg : MaxPos;
                        flags_d = 3'b010;
                    end else if (ue < 0) begin
                        // |x| < 1 truncates to +0 regardless of sign
                        data_d  = '0;
                        flags_d = {2'b00, (|exp_f) | man_nz};
                    end else if (ue > IwM1 || (ue == IwM1 && !(sgn && !man_nz))) begin
                        // Only exactly -2^(IW-1) fits at the top exponent
                        data_d  = sgn ? MinNeg : MaxPos;
                        flags_d = 3'b010;
                    end else begin
                        left_d = (ue > MI);
                        cnt_d  = CW'((ue > MI) ? (ue - MI) : (MI - ue));
                        if (ue == MI) begin
                            data_d  = sgn ? -acc_init : acc_init;
                            flags_d = 3'b000;
                        end else begin
                            state_d = StShift;
                        end
                    end
                end
            end
            StShift: begin
                if (left_q) begin
                    acc_d = {acc_q[IW-2:0], 1'b0};
                end else begin
                    acc_d    = {1'b0, acc_q[IW-1:1]};
                    sticky_d = sticky_q | acc_q[0];
                end
                cnt_d = cnt_q - CW'(1);
                // Last shift and result formation share the same cycle
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    data_d  = sign_q ? -acc_d : acc_d;
                    flags_d = {2'b00, sticky_d};
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            data_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: a vector table of operands with
// hand-computed results, flags and latency, then backpressure and
// mid-conversion reset sequences.
module tb_float_to_int;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    float_to_int_if #(.Width(32), .IW(32)) bus ();

    float_to_int dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // lat: number of edges after the accept edge until out_valid is sampled high
    typedef struct {
        logic [31:0] f;
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends just after a falling edge; in_ready assumed high on entry
    task automatic run_one(input logic [31:0] f, output logic [31:0] d,
                           output logic [2:0] fl, output int lat);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hA5A5_5A5A;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        d  = bus.out_data;
        fl = bus.out_flags;
        if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        int          waited;
        logic        dropped;

        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 3'b000, 24});  // 1.0
        vecs.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 23});  // -2.5
        vecs.push_back('{32'h4E80_0000, 32'h4000_0000, 3'b000, 8});   // 2^30
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 3'b000, 9});   // -2^31
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1});   // +2^31
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1});   // NaN
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 3'b010, 1});   // -Inf
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 3'b010, 1});   // +Inf
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 3'b001, 1});   // 0.5
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 3'b000, 1});   // -0
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 3'b001, 1});   // denormal
        vecs.push_back('{32'hBF7F_FFFF, 32'h0000_0000, 3'b001, 1});   // -0.99999994
        vecs.push_back('{32'h4040_0000, 32'h0000_0003, 3'b000, 23});  // 3.0
        vecs.push_back('{32'h3FC0_0000, 32'h0000_0001, 3'b001, 24});  // 1.5
        vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 3'b000, 1});   // 2^23, no shift
        vecs.push_back('{32'hCB7F_FFFF, 32'hFF00_0001, 3'b000, 1});   // -(2^24-1)
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 8});   // largest < 2^31
        vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 3'b010, 1});   // just below -2^31
        vecs.push_back('{32'hDF00_0000, 32'h8000_0000, 3'b010, 1});   // -2^63

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset out_data", bus.out_data, 32'd0);
        check("reset out_flags", {29'd0, bus.out_flags}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_one(vecs[i].f, d, fl, lat);
            check($sformatf("vec%0d %08h data", i, vecs[i].f), d, vecs[i].d);
            check($sformatf("vec%0d %08h flags", i, vecs[i].f), {29'd0, fl}, {29'd0, vecs[i].fl});
            check($sformatf("vec%0d %08h latency", i, vecs[i].f), lat, vecs[i].lat);
        end

        // Backpressure: result must hold while the consumer stalls
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hC020_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        waited = 0;
        while (!bus.out_valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("bp reached done", {31'd0, bus.out_valid}, 32'd1);
        // A new operand offered during DONE must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7FC0_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp c%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp c%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
            check($sformatf("bp c%0d data", c), bus.out_data, 32'hFFFF_FFFE);
            check($sformatf("bp c%0d flags", c), {29'd0, bus.out_flags}, 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a shift drops the conversion silently
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F80_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid in_ready busy", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid rst out_data", bus.out_data, 32'd0);
        dropped = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) dropped = 1'b1;
        end
        check("mid rst no output", {31'd0, dropped}, 32'd0);
        run_one(32'h4040_0000, d, fl, lat);
        check("post rst 3.0 data", d, 32'h0000_0003);
        check("post rst 3.0 flags", {29'd0, fl}, 32'd0);
        check("post rst 3.0 latency", lat, 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
